// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator delta decoder: default widths,
// decoder FSM states and the layout of one output FIFO entry.
package acc_pkg;

  localparam int SUM_W_DEF   = 5;
  localparam int DELTA_W_DEF = 4;
  localparam int CNT_W_DEF   = 8;

  // FIFO entry layout, MSB to LSB: {delta[DELTA_W-1:0], wrap, ovf}
  localparam int FLAG_W       = 2;
  localparam int ENT_WRAP_BIT = 1;
  localparam int ENT_OVF_BIT  = 0;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } acc_state_e;

  function automatic int entry_w(input int delta_w);
    return delta_w + FLAG_W;
  endfunction

endpackage

// File: rtl/acc_fifo2.sv
// Two-entry synchronous FIFO with valid/ready handshakes on both sides.
// Storage is left unreset; only pointers and occupancy are cleared.
module acc_fifo2 #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/acc_delta_decoder.sv
// Recovers per-sample increments from a free-running modulo-2^SUM_W
// accumulator stream, flagging modulus wrap and increment overflow.
module acc_delta_decoder
  import acc_pkg::*;
#(
  parameter int SUM_W   = SUM_W_DEF,
  parameter int DELTA_W = DELTA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sum_valid,
  output logic               sum_ready,
  input  logic [SUM_W-1:0]   sum_data,
  input  logic               sum_clr,
  output logic               delta_valid,
  input  logic               delta_ready,
  output logic [DELTA_W-1:0] delta_data,
  output logic               delta_wrap,
  output logic               delta_ovf,
  output logic               err_sticky,
  output logic [CNT_W-1:0]   sample_cnt
);

  localparam int EW = entry_w(DELTA_W);
  localparam int XW = (SUM_W > DELTA_W) ? SUM_W : DELTA_W;

  acc_state_e        state_q;
  acc_state_e        state_d;
  logic [SUM_W-1:0]  prev_sum;
  logic              accept;
  logic              fifo_in_ready;
  logic [SUM_W-1:0]  base;
  logic [SUM_W-1:0]  diff_p0;
  logic              wrap_p0;
  logic              ovf_p0;
  logic [EW-1:0]     entry_p0;
  logic              vld_p1;
  logic [EW-1:0]     head_p1;

  // Any bit of the modulo difference above DELTA_W means it will not fit.
  function automatic logic calc_ovf(input logic [SUM_W-1:0] d);
    logic [XW-1:0] x;
    x = XW'(d);
    return (x >> DELTA_W) != '0;
  endfunction

  function automatic logic [DELTA_W-1:0] trunc_delta(input logic [SUM_W-1:0] d);
    logic [XW-1:0] x;
    x = XW'(d);
    return x[DELTA_W-1:0];
  endfunction

  assign sum_ready = fifo_in_ready;
  assign accept    = sum_valid && sum_ready;

  always_comb begin
    state_d = state_q;
    if (accept) state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= PRIME;
    else      state_q <= state_d;
  end

  // Stage p0: difference against the held sum, or against zero after a clear
  assign base     = ((state_q == PRIME) || sum_clr) ? '0 : prev_sum;
  assign diff_p0  = sum_data - base;
  assign wrap_p0  = (state_q == RUN) && !sum_clr && (sum_data < prev_sum);
  assign ovf_p0   = calc_ovf(diff_p0);
  assign entry_p0 = {trunc_delta(diff_p0), wrap_p0, ovf_p0};

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_sum   <= '0;
      sample_cnt <= '0;
      err_sticky <= 1'b0;
    end else if (accept) begin
      prev_sum   <= sum_data;
      sample_cnt <= sample_cnt + 1'b1;
      if (ovf_p0) err_sticky <= 1'b1;
    end
  end

  acc_fifo2 #(
    .W (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (sum_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (entry_p0),
    .out_valid (vld_p1),
    .out_ready (delta_ready),
    .out_data  (head_p1)
  );

  // Stage p1: FIFO head, forced to zero whenever nothing is buffered
  assign delta_valid = vld_p1;
  assign delta_data  = vld_p1 ? head_p1[EW-1:FLAG_W] : '0;
  assign delta_wrap  = vld_p1 && head_p1[ENT_WRAP_BIT];
  assign delta_ovf   = vld_p1 && head_p1[ENT_OVF_BIT];

endmodule
